// File: rtl/mic_level_meter.sv
// Peak-deviation volume meter: tracks the largest |sample - MIDSCALE| over each
// window of WINDOW samples and maps it to a 0..15 level with instant attack and one-step decay.
module mic_level_meter #(
    parameter int unsigned WINDOW   = 4000,
    parameter logic [11:0] MIDSCALE = 12'd2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    output logic [3:0]  mic_data,
    output logic [10:0] peak_hold,
    output logic        level_valid
);

    localparam logic [15:0] LAST_CNT = 16'(WINDOW - 1);

    typedef enum logic {
        ST_ACCUM,
        ST_CLOSE
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [10:0] peak_q, peak_d;
    logic [10:0] wpeak_q, wpeak_d;
    logic [3:0]  mic_q, mic_d;
    logic [10:0] hold_q, hold_d;
    logic        lv_q, lv_d;

    logic [11:0] dev_raw;
    logic [10:0] dev;
    logic [10:0] dev_max;
    logic [3:0]  new_level;
    logic        closing;

    // Compare-then-subtract keeps the magnitude unsigned; only sample=0 exceeds 11 bits.
    always_comb begin
        if (sample >= MIDSCALE) begin
            dev_raw = sample - MIDSCALE;
        end else begin
            dev_raw = MIDSCALE - sample;
        end
        dev       = dev_raw[11] ? 11'h7FF : dev_raw[10:0];
        dev_max   = (dev > peak_q) ? dev : peak_q;
        closing   = sample_valid && (cnt_q == LAST_CNT);
        new_level = wpeak_q[10:7];
    end

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        peak_d  = peak_q;
        wpeak_d = wpeak_q;
        mic_d   = mic_q;
        hold_d  = hold_q;
        lv_d    = 1'b0;

        // Accumulation runs in both states, so a sample landing in CLOSE starts the next window.
        if (sample_valid) begin
            if (closing) begin
                wpeak_d = dev_max;
                peak_d  = '0;
                cnt_d   = '0;
            end else begin
                peak_d  = dev_max;
                cnt_d   = cnt_q + 16'd1;
            end
        end

        case (state_q)
            ST_ACCUM: begin
                if (closing) begin
                    state_d = ST_CLOSE;
                end
            end
            ST_CLOSE: begin
                hold_d = wpeak_q;
                lv_d   = 1'b1;
                if (new_level >= mic_q) begin
                    mic_d = new_level;
                end else begin
                    mic_d = mic_q - 4'd1;
                end
                state_d = closing ? ST_CLOSE : ST_ACCUM;
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
            peak_q  <= '0;
            wpeak_q <= '0;
            mic_q   <= '0;
            hold_q  <= '0;
            lv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            peak_q  <= peak_d;
            wpeak_q <= wpeak_d;
            mic_q   <= mic_d;
            hold_q  <= hold_d;
            lv_q    <= lv_d;
        end
    end

    assign mic_data    = mic_q;
    assign peak_hold   = hold_q;
    assign level_valid = lv_q;

endmodule

// File: tb/tb_mic_level_meter.sv
// Scoreboard bench for mic_level_meter (WINDOW=4): a window-level reference model
// predicts each level_valid pulse; a monitor pops and compares as pulses appear.
module tb_mic_level_meter;

    localparam int WINDOW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [11:0] sample;
    logic [3:0]  mic_data;
    logic [10:0] peak_hold;
    logic        level_valid;

    mic_level_meter #(.WINDOW(WINDOW), .MIDSCALE(12'd2048)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .mic_data     (mic_data),
        .peak_hold    (peak_hold),
        .level_valid  (level_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int peak;
        int mic;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   win_q[$];
    int   pulse_q[$];
    int   mic_m = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_dev(input int s);
        int d;
        d = s - 2048;
        if (d < 0) d = -d;
        if (d > 2047) d = 2047;
        return d;
    endfunction

    // Window-level model: level = peak/128, rise to it or fall by one.
    task automatic model_sample(input int s, input int due);
        int pk;
        int lvl;
        win_q.push_back(ref_dev(s));
        if (win_q.size() == WINDOW) begin
            pk = 0;
            foreach (win_q[i]) if (win_q[i] > pk) pk = win_q[i];
            lvl   = pk / 128;
            mic_m = (lvl >= mic_m) ? lvl : mic_m - 1;
            exp_q.push_back('{peak: pk, mic: mic_m, due: due});
            win_q.delete();
        end
    endtask

    // Samples are launched on the falling edge; the pulse is due two rising edges after capture.
    task automatic send(input int s, input int gap);
        @(negedge clk);
        sample_valid = 1'b1;
        sample       = 12'(s);
        model_sample(s, cyc + 2);
        if (gap > 0) begin
            @(negedge clk);
            sample_valid = 1'b0;
            sample       = 12'($urandom);
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic drain();
        @(negedge clk);
        sample_valid = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset        = 1'b1;
        sample_valid = 1'b0;
        @(negedge clk);
        win_q.delete();
        exp_q.delete();
        mic_m = 0;
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mic_data", mic_data, 0);
        check("rst_peak_hold", peak_hold, 0);
        check("rst_level_valid", level_valid, 0);
    endtask

    task automatic expect_now(input string name, input int pk, input int mic);
        check({name, "_peak"}, peak_hold, pk);
        check({name, "_mic"}, mic_data, mic);
    endtask

    // Monitor: compares every pulse against the scoreboard and holds outputs stable between pulses.
    int last_mic = 0;
    int last_hold = 0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_mic  = 0;
            last_hold = 0;
        end else if (level_valid) begin
            pulse_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("stray_pulse_pending", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("peak_hold", peak_hold, e.peak);
                check("mic_data", mic_data, e.mic);
                check("latency", cyc, e.due);
            end
            last_mic  = mic_data;
            last_hold = peak_hold;
        end else begin
            check("mic_stable", mic_data, last_mic);
            check("hold_stable", peak_hold, last_hold);
            if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                check("missing_pulse", cyc, exp_q[0].due + 1000);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample       = 12'd0;
        repeat (3) @(negedge clk);
        check("por_mic_data", mic_data, 0);
        check("por_peak_hold", peak_hold, 0);
        check("por_level_valid", level_valid, 0);
        #1 reset = 1'b0;

        // Partial window of loud samples is discarded by a mid-window reset.
        send(4095, 1);
        send(4095, 1);
        do_reset();

        send(2048, 1); send(2048, 2); send(2048, 1); send(2048, 1);
        drain();
        expect_now("silence", 0, 0);

        send(2048, 1); send(2248, 1); send(1748, 1); send(2048, 1);
        drain();
        expect_now("quant300", 300, 2);

        send(2048, 1); send(0, 1); send(2048, 1); send(2048, 1);
        drain();
        expect_now("clip_zero", 2047, 15);

        send(2048, 1); send(2048, 1); send(4095, 1); send(2048, 1);
        drain();
        expect_now("clip_4095", 2047, 15);

        for (int w = 0; w < 3; w++) begin
            repeat (WINDOW) send(2048, 1);
            drain();
            check("decay_mic", mic_data, 14 - w);
        end

        send(3048, 1); send(2048, 1); send(2048, 1); send(2048, 1);
        drain();
        expect_now("decay_floor", 1000, 11);

        send(2048, 1); send(3648, 1); send(2048, 1); send(2048, 1);
        drain();
        expect_now("attack", 1600, 12);

        send(2048, 1); send(2048, 1); send(2048, 1); send(3968, 1);
        drain();
        expect_now("closing_counts", 1920, 15);

        // Back-to-back samples straddling the CLOSE cycle.
        do_reset();
        pulse_q.delete();
        for (int i = 0; i < 8; i++) send(2177, (i == 7) ? 1 : 0);
        drain();
        check("b2b_pulses", pulse_q.size(), 2);
        if (pulse_q.size() == 2) check("b2b_spacing", pulse_q[1] - pulse_q[0], 4);
        expect_now("b2b", 129, 1);

        // Randomized traffic with occasional mid-window resets.
        for (int n = 0; n < 700; n++) begin
            int s;
            case ($urandom_range(0, 4))
                0: s = int'($urandom_range(0, 4095));
                1: s = 2048 + int'($urandom_range(0, 600)) - 300;
                2: s = ($urandom_range(0, 1) == 1) ? 0 : 4095;
                3: s = 2048 + int'($urandom_range(0, 255)) - 128;
                default: s = 2048;
            endcase
            send(s, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 149) == 0) begin
                drain();
                do_reset();
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
